// File: rtl/pingpong_window_feed.sv
// Two-bank ping/pong byte-window feeder for the muxpang_pipe5 realignment stage.
// Optional sticky protocol-error flag `err` is built when PINGFEED_ERR_EN is defined.
module pingpong_window_feed #(
  parameter int BW = 8,
  parameter int NB = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [BW*NB-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BW*NB-1:0]     d_bus,
  output logic                 d_valid,
  output logic [$clog2(NB)-1:0] next_sft,
  input  logic                 cons_valid,
  input  logic [$clog2(NB):0]  cons_len,
  output logic [1:0]           fill_lvl
`ifdef PINGFEED_ERR_EN
  ,
  output logic                 err
`endif
);

  localparam int SW = $clog2(NB);
  localparam int DW = BW * NB;
  localparam logic [SW:0] LEN_MAX = NB[SW:0];

  logic [DW-1:0] bank_q [2];
  logic [DW-1:0] bank_d [2];
  logic [1:0]    bv_q, bv_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [SW-1:0] offset_q, offset_d;

  logic          wr_fire;
  logic          cons_fire;
  logic [SW:0]   len_eff;
  logic [SW+1:0] sum;

  // All outputs are taken from flops only; nothing from the inputs reaches them.
  assign in_ready = ~bv_q[wr_sel_q];
  assign d_valid  = bv_q[rd_sel_q];
  assign d_bus    = bank_q[rd_sel_q];
  assign next_sft = offset_q;
  assign fill_lvl = {1'b0, bv_q[0]} + {1'b0, bv_q[1]};

  assign wr_fire   = in_valid & in_ready;
  assign cons_fire = cons_valid & d_valid;
  assign len_eff   = (cons_len > LEN_MAX) ? LEN_MAX : cons_len;
  assign sum       = {2'b00, offset_q} + {1'b0, len_eff};

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    bank_d   = bank_q;
    bv_d     = bv_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    offset_d = offset_q;
    if (flush) begin
      bank_d[0] = '0;
      bank_d[1] = '0;
      bv_d      = '0;
      wr_sel_d  = 1'b0;
      rd_sel_d  = 1'b0;
      offset_d  = '0;
    end else begin
      // Carry-over into the next bank is just the low bits of the sum.
      if (cons_fire) begin
        offset_d = sum[SW-1:0];
        if (sum >= {1'b0, LEN_MAX}) begin
          bv_d[rd_sel_q] = 1'b0;
          rd_sel_d       = ~rd_sel_q;
        end
      end
      // A write only targets an empty bank, so it never collides with a release.
      if (wr_fire) begin
        bank_d[wr_sel_q] = in_data;
        bv_d[wr_sel_q]   = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end
    end
  end

  // NOTE: the bank storage is reset as well, so d_bus is a defined zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
      bv_q      <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      offset_q  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only.
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      bv_q      <= bv_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      offset_q  <= offset_d;
    end
  end

`ifdef PINGFEED_ERR_EN
  logic          err_q, err_d;
  logic [DW-1:0] prev_data_q, prev_data_d;

  assign err = err_q;

  always_comb begin
    err_d       = err_q;
    prev_data_d = in_data;
    if (flush) begin
      err_d = 1'b0;
    end else if ((cons_valid && !d_valid && cons_len != '0) ||
                 (cons_valid && cons_len > LEN_MAX) ||
                 (in_valid && !in_ready && in_data != prev_data_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q       <= 1'b0;
      prev_data_q <= '0;
    end else begin
      err_q       <= err_d;
      prev_data_q <= prev_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_pingpong_window_feed.sv
// Directed bench for pingpong_window_feed: a beat-queue model checked every cycle,
// plus hand-computed literal expectations along the scenario.
module tb_pingpong_window_feed;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] d_bus;
  logic         d_valid;
  logic [3:0]   next_sft;
  logic         cons_valid;
  logic [4:0]   cons_len;
  logic [1:0]   fill_lvl;
`ifdef PINGFEED_ERR_EN
  logic         err;
`endif

  int errors = 0;
  int checks = 0;

  pingpong_window_feed dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .d_bus(d_bus), .d_valid(d_valid), .next_sft(next_sft),
    .cons_valid(cons_valid), .cons_len(cons_len), .fill_lvl(fill_lvl)
`ifdef PINGFEED_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_beat(input logic [7:0] base);
    logic [127:0] b;
    for (int k = 0; k < 16; k++) b[8*k +: 8] = base + 8'(k);
    return b;
  endfunction

  // Model: the buffer is a FIFO of at most two beats plus a read offset into the head.
  logic [127:0] mq[$];
  int           moff;
  bit           m_acc, m_con;
  int           m_len, m_s;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      moff = 0;
    end else if (flush) begin
      mq.delete();
      moff = 0;
    end else begin
      m_acc = in_valid && (mq.size() < 2);
      m_con = cons_valid && (mq.size() > 0);
      if (m_con) begin
        m_len = (cons_len > 16) ? 16 : int'(cons_len);
        m_s   = moff + m_len;
        if (m_s >= 16) begin
          void'(mq.pop_front());
          moff = m_s - 16;
        end else begin
          moff = m_s;
        end
      end
      if (m_acc) mq.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready", 128'(in_ready), 128'(mq.size() < 2));
      check("d_valid",  128'(d_valid),  128'(mq.size() > 0));
      check("next_sft", 128'(next_sft), 128'(moff));
      check("fill_lvl", 128'(fill_lvl), 128'(mq.size()));
      if (mq.size() > 0) check("d_bus", d_bus, mq[0]);
    end
  end

  // Apply one cycle of inputs; returns #1 after the edge that consumed them.
  task automatic step(input logic iv, input logic [127:0] data,
                      input logic cv, input logic [4:0] len, input logic fl);
    in_valid   = iv;
    in_data    = data;
    cons_valid = cv;
    cons_len   = len;
    flush      = fl;
    @(posedge clk);
    #1;
  endtask

  logic [127:0] bA, bB, bC, bD, bE, bF, bG;

  initial begin
    bA = mk_beat(8'h00); bB = mk_beat(8'h10); bC = mk_beat(8'h20);
    bD = mk_beat(8'h30); bE = mk_beat(8'h40); bF = mk_beat(8'h50);
    bG = mk_beat(8'h60);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    cons_valid = 1'b0; cons_len = '0;
    #3;
    check("rst in_ready", 128'(in_ready), 128'd1);
    check("rst d_valid",  128'(d_valid),  128'd0);
    check("rst next_sft", 128'(next_sft), 128'd0);
    check("rst d_bus",    d_bus,          128'd0);
    check("rst fill_lvl", 128'(fill_lvl), 128'd0);
`ifdef PINGFEED_ERR_EN
    check("rst err",      128'(err),      128'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    step(0, '0, 0, 0, 0);

    // Beat A visible one cycle after acceptance.
    step(1, bA, 0, 0, 0);
    check("A d_valid",  128'(d_valid),   128'd1);
    check("A byte0",    128'(d_bus[7:0]), 128'h00);
    check("A byte15",   128'(d_bus[127:120]), 128'h0F);
    check("A fill",     128'(fill_lvl),  128'd1);
    check("A in_ready", 128'(in_ready),  128'd1);

    // B fills the second bank; C stalls.
    step(1, bB, 0, 0, 0);
    check("AB fill",     128'(fill_lvl), 128'd2);
    check("AB in_ready", 128'(in_ready), 128'd0);
    step(1, bC, 0, 0, 0);
    check("C stall fill", 128'(fill_lvl), 128'd2);

    // Consume 5, 7, 6 on A while C is held.
    step(1, bC, 1, 5'd5, 0);
    check("cons5 sft", 128'(next_sft), 128'd5);
    step(1, bC, 1, 5'd7, 0);
    check("cons7 sft", 128'(next_sft), 128'd12);
    step(1, bC, 1, 5'd6, 0);
    check("relA byte0", 128'(d_bus[7:0]), 128'h10);
    check("relA sft",   128'(next_sft),   128'd2);
    check("relA fill",  128'(fill_lvl),   128'd1);
    step(1, bC, 0, 0, 0);
    check("C accepted fill", 128'(fill_lvl), 128'd2);

    // Drain B exactly, move to offset 10 in C, then release C with 16.
    step(0, '0, 1, 5'd14, 0);
    check("relB byte0", 128'(d_bus[7:0]), 128'h20);
    check("relB sft",   128'(next_sft),   128'd0);
    step(0, '0, 1, 5'd10, 0);
    check("C sft10", 128'(next_sft), 128'd10);
    step(0, '0, 1, 5'd16, 0);
    check("relC d_valid", 128'(d_valid),  128'd0);
    check("relC sft",     128'(next_sft), 128'd10);
    check("relC fill",    128'(fill_lvl), 128'd0);
    step(1, bD, 0, 0, 0);
    check("D byte0", 128'(d_bus[7:0]), 128'h30);
    check("D sft",   128'(next_sft),   128'd10);

    // Both full; release and write in the same cycle: write waits one cycle.
    step(1, bE, 0, 0, 0);
    check("DE fill", 128'(fill_lvl), 128'd2);
    step(1, bF, 1, 5'd16, 0);
    check("sim rel fill", 128'(fill_lvl), 128'd1);
    check("sim rel sft",  128'(next_sft), 128'd10);
    step(1, bF, 0, 0, 0);
    check("sim acc fill", 128'(fill_lvl), 128'd2);

    // Over-length consume clamps to 16; zero-length consume changes nothing.
    step(0, '0, 1, 5'd20, 0);
    check("clamp byte0", 128'(d_bus[7:0]), 128'h50);
    check("clamp sft",   128'(next_sft),   128'd10);
    step(0, '0, 1, 5'd0, 0);
    check("len0 sft", 128'(next_sft), 128'd10);

    // Flush overrides a write and a release in the same cycle.
    step(1, bG, 0, 0, 0);
    step(1, bA, 1, 5'd16, 1);
    check("flush fill",    128'(fill_lvl), 128'd0);
    check("flush sft",     128'(next_sft), 128'd0);
    check("flush d_valid", 128'(d_valid),  128'd0);
    check("flush in_rdy",  128'(in_ready), 128'd1);
`ifdef PINGFEED_ERR_EN
    check("flush err", 128'(err), 128'd0);
`endif
    step(0, '0, 1, 5'd3, 0);
    check("empty cons sft", 128'(next_sft), 128'd0);
`ifdef PINGFEED_ERR_EN
    check("err set", 128'(err), 128'd1);
    step(0, '0, 0, 0, 0);
    check("err sticky", 128'(err), 128'd1);
`endif
    step(1, bB, 0, 0, 0);
    check("post flush byte0", 128'(d_bus[7:0]), 128'h10);
    step(0, '0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pingpong_window_feed.md
Name: pingpong_window_feed

Overview:
- Upstream feeder for the muxpang_pipe5 byte-realignment stage.
- Accepts 16-byte input beats into a two-bank (ping/pong) buffer.
- Presents the current bank as d00..d15, plus the 4-bit read offset next_sft into that bank.
- Advances the offset and swaps banks as the downstream parser consumes bytes.

Parameters:
- BW, 8, bits per byte lane (fixed at 8 for the muxpang datapath).
- NB, 16, byte lanes per bank (fixed; next_sft width is log2(NB)=4).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of all buffer state
- in_data  in  128  input beat; byte k at [8k+7:8k], byte 0 = oldest
- in_valid  in  1  input beat valid
- in_ready  out  1  feeder can accept a beat this cycle
- d_bus  out  128  current read bank; byte k drives dk (d00..d15) of muxpang_pipe5
- d_valid  out  1  current read bank holds valid data
- next_sft  out  4  byte offset of the next unconsumed byte in d_bus
- cons_valid  in  1  downstream consumed cons_len bytes this cycle
- cons_len  in  5  bytes consumed, 0..16
- fill_lvl  out  2  number of valid banks (0..2)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values (every output and state element):
  - bank valid bits bv[1:0]=0, wr_sel=0, rd_sel=0, offset=0, bank contents=0.
  - Outputs therefore reset to: in_ready=1, d_valid=0, next_sft=0, d_bus=0, fill_lvl=0.
- Output timing:
  - in_ready = ~bv[wr_sel], combinational from registers only.
  - d_valid = bv[rd_sel]; d_bus = bank[rd_sel]; next_sft = offset.
  - All outputs come from flops through the rd_sel mux. No input-to-output combinational path.
- Write:
  - On in_valid & in_ready: bank[wr_sel] <= in_data, bv[wr_sel] <= 1, wr_sel toggles.
  - The data is visible on d_bus one cycle after acceptance, if that bank is rd_sel.
- Consume (acted on only when cons_valid & d_valid):
  - sum = offset + cons_len, 6-bit.
  - sum < 16: offset <= sum[3:0]. Bank is kept.
  - sum >= 16: bank released. bv[rd_sel] <= 0, rd_sel toggles, offset <= sum-16 (carry-over into the next bank, 0..15).
  - cons_len = 0: no state change.
  - cons_len > 16: treated as 16.
  - cons_valid while d_valid=0: ignored; offset unchanged.
- Simultaneous write and release:
  - in_ready uses pre-update bv, so there is no same-cycle bypass.
  - With both banks full, wr_sel==rd_sel and in_ready=0. A release in that cycle lets a write be accepted from the next cycle.
  - With one bank full and the other empty, write and release in the same cycle are both performed. fill_lvl stays 1.
- fill_lvl = bv[0]+bv[1], registered-derived.
- Flush:
  - flush=1 sets all state to reset values on the next edge.
  - It overrides a write or consume in the same cycle.
- Reset mid-operation: all banks are discarded immediately. No partial beat survives.

Optional Feature:
- Macro: PINGFEED_ERR_EN.
- When defined:
  - Adds output err (1 bit, reset 0), sticky until reset or flush.
  - err sets on: cons_valid with d_valid=0 and cons_len!=0; cons_len>16; in_valid while in_ready=0 and in_data changes vs. the previous cycle (held-beat violation).
- When not defined: no err port. Illegal cases are handled silently as described in Behaviour.

Test Plan:
- Reset, then write beat A (bytes 0x00..0x0F) → 1 cycle later d_valid=1, d_bus byte0=0x00, next_sft=0, fill_lvl=1, in_ready=1.
- Write A and B (0x10..0x1F), no consume → fill_lvl=2, in_ready=0. A third beat stalls until the release.
- With A loaded: consume 5, then 7 → next_sft=5, then 12. Consume 6 → A released, d_bus=B, next_sft=2, fill_lvl=1.
- Only A loaded, offset 10: consume 16 → A released, d_valid=0, next_sft=10. Write C → d_bus=C, next_sft=10.
- Both banks full, same cycle cons_len=16 and in_valid → release happens, beat not accepted. Accepted next cycle; fill_lvl goes 2→1→2.
- Flush asserted with in_valid and cons_valid high, banks full → next cycle fill_lvl=0, next_sft=0, d_valid=0. With PINGFEED_ERR_EN, consume while empty afterwards → err=1 and stays 1.
